// File: rtl/gray_pkg.sv
// Shared definitions for the sequential Gray-to-binary decoder.
// Holds the FSM state encoding and the default data width.
package gray_pkg;

    localparam int GRAY_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_DONE   = 2'd2
    } gray_state_t;

endpackage

// File: rtl/gray_hamming_gt1.sv
// Flags when two W-bit words differ in more than one bit position.
// Used by the decoder's optional Gray step check (GRAY_DEC_STEP_CHECK_EN).
module gray_hamming_gt1
    import gray_pkg::*;
#(
    parameter int W = GRAY_W_DEFAULT
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt1
);

    logic [W-1:0] diff;

    // Clearing the lowest set bit of the difference leaves something only
    // when at least two bits differ, so no adder tree is needed.
    assign diff = a ^ b;
    assign gt1  = |(diff & (diff - W'(1)));

endmodule

// File: rtl/gray_to_bin_decoder.sv
// Sequential Gray-to-binary decoder, one binary bit per clock, MSB first.
// start/busy/done handshake; bin_out changes only on completion.
// Optional macro GRAY_DEC_STEP_CHECK_EN adds step_err, which flags an accepted
// Gray word that differs from the previously accepted one in more than one bit.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for start; g_in captured on accept
//   ST_DECODE | resolving bit cnt_q = prev ^ gshadow[cnt_q], W cycles
//   ST_DONE   | one cycle; result and done pulse registered on leaving
module gray_to_bin_decoder
    import gray_pkg::*;
#(
    parameter int W = GRAY_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] g_in,
    input  logic         start,
    output logic [W-1:0] bin_out,
    output logic         busy,
    output logic         done
`ifdef GRAY_DEC_STEP_CHECK_EN
    ,
    output logic         step_err
`endif
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(W - 1);

    gray_state_t   state_q, state_d;
    logic [W-1:0]  gsh_q, gsh_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          prev_q, prev_d;
    logic [W-1:0]  bin_q, bin_d;
    logic          done_q, done_d;
    logic          bit_v;
    logic          accept;

    assign accept  = (state_q == ST_IDLE) && start;
    assign busy    = (state_q != ST_IDLE);
    assign bin_out = bin_q;
    assign done    = done_q;

    // Core state, shadow, accumulator and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gsh_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
            bin_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gsh_q   <= gsh_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            bin_q   <= bin_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: capture on accept, resolve one bit per DECODE cycle.
    always_comb begin
        state_d = state_q;
        gsh_d   = gsh_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prev_d  = prev_q;
        bin_d   = bin_q;
        done_d  = 1'b0;
        bit_v   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    gsh_d   = g_in;
                    acc_d   = '0;
                    cnt_d   = CNT_MAX;
                    prev_d  = 1'b0;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                bit_v        = prev_q ^ gsh_q[cnt_q];
                acc_d[cnt_q] = bit_v;
                prev_d       = bit_v;
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DONE: begin
                bin_d   = acc_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef GRAY_DEC_STEP_CHECK_EN
    logic [W-1:0] gprev_q, gprev_d;
    logic         seen_q, seen_d;
    logic         pend_q, pend_d;
    logic         step_q, step_d;
    logic         far_step;

    gray_hamming_gt1 #(.W(W)) u_ham (
        .a   (g_in),
        .b   (gprev_q),
        .gt1 (far_step)
    );

    assign step_err = step_q;

    // Step-check registers: last accepted word, first-sample flag, result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gprev_q <= '0;
            seen_q  <= 1'b0;
            pend_q  <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            gprev_q <= gprev_d;
            seen_q  <= seen_d;
            pend_q  <= pend_d;
            step_q  <= step_d;
        end
    end

    // Judge the step at accept time; publish it alongside done.
    always_comb begin
        gprev_d = gprev_q;
        seen_d  = seen_q;
        pend_d  = pend_q;
        step_d  = step_q;
        if (accept) begin
            gprev_d = g_in;
            seen_d  = 1'b1;
            pend_d  = seen_q & far_step;
        end
        if (state_q == ST_DONE) begin
            step_d = pend_q;
        end
    end
`endif

endmodule

// File: tb/tb_gray_to_bin_decoder.sv
module tb_gray_to_bin_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] g4, bin4;
    logic       start4, busy4, done4;
    logic [7:0] g8, bin8;
    logic       start8, busy8, done8;
`ifdef GRAY_DEC_STEP_CHECK_EN
    logic       step4, step8;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gray_to_bin_decoder #(.W(4)) u4 (
        .clk(clk), .rst(rst), .g_in(g4), .start(start4),
        .bin_out(bin4), .busy(busy4), .done(done4)
`ifdef GRAY_DEC_STEP_CHECK_EN
        , .step_err(step4)
`endif
    );

    gray_to_bin_decoder #(.W(8)) u8 (
        .clk(clk), .rst(rst), .g_in(g8), .start(start8),
        .bin_out(bin8), .busy(busy8), .done(done8)
`ifdef GRAY_DEC_STEP_CHECK_EN
        , .step_err(step8)
`endif
    );

    typedef struct {
        logic [3:0] g;
        logic [3:0] b;
        bit         intrude;
        string      name;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: the binary value whose Gray code (b ^ b>>1) equals g.
    function automatic logic [7:0] ref_bin(input logic [7:0] g, input int w);
        for (int b = 0; b < (1 << w); b++) begin
            if (((b ^ (b >> 1)) & ((1 << w) - 1)) == int'(g)) return b[7:0];
        end
        return 8'h00;
    endfunction

    function automatic logic [3:0] ref4(input logic [3:0] g);
        logic [7:0] r;
        r = ref_bin({4'b0000, g}, 4);
        return r[3:0];
    endfunction

    task automatic do_reset();
        rst    = 1'b1;
        start4 = 1'b0;
        start8 = 1'b0;
        g4     = '0;
        g8     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // One isolated decode on the W=4 instance with timing/handshake checks.
    task automatic run_one(input logic [3:0] g, input logic [3:0] exp, input bit intrude,
                           input string name, output logic st);
        int   busy_n  = 0;
        int   done_n  = 0;
        int   done_at = -1;
        bit   partial = 0;
        logic [3:0] held;
        st = 1'b0;
        @(negedge clk);
        held   = bin4;
        g4     = g;
        start4 = 1'b1;
        for (int s = 1; s <= 16; s++) begin
            @(negedge clk);
            if (busy4) busy_n++;
            if (done4) begin
                done_n++;
                if (done_at < 0) done_at = s - 1;
`ifdef GRAY_DEC_STEP_CHECK_EN
                st = step4;
`endif
            end else if (done_n == 0 && bin4 !== held) begin
                partial = 1;
            end
            if (s == 1) begin
                start4 = 1'b0;
                g4     = 4'($urandom);
            end
            if (intrude && s == 2) begin
                start4 = 1'b1;
                g4     = 4'b1100;
            end
            if (intrude && s == 3) start4 = 1'b0;
        end
        check({name, "_bin"},     bin4,    exp);
        check({name, "_busy"},    busy_n,  5);
        check({name, "_done_n"},  done_n,  1);
        check({name, "_done_at"}, done_at, 5);
        check({name, "_partial"}, partial, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       st;
        logic [3:0] rv;
        logic [7:0] mask, sent;
        logic [7:0] q8[$];
        int         k_acc, k_done, last_done, cyc, dn;
        logic       prev_busy;

        tbl[0] = '{4'b0110, 4'b0100, 1'b0, "basic"};
        tbl[1] = '{4'b0000, 4'b0000, 1'b0, "zero"};
        tbl[2] = '{4'b1000, 4'b1111, 1'b0, "msb"};
        tbl[3] = '{4'b1111, 4'b1010, 1'b0, "ones"};
        tbl[4] = '{4'b0011, 4'b0010, 1'b1, "ignored_start"};

        do_reset();
        @(negedge clk);
        check("rst_bin",  bin4,  0);
        check("rst_busy", busy4, 0);
        check("rst_done", done4, 0);
        check("rst_bin8", bin8,  0);

        foreach (tbl[i]) run_one(tbl[i].g, tbl[i].b, tbl[i].intrude, tbl[i].name, st);

        // Reset in the middle of a decode.
        @(negedge clk);
        g4 = 4'b1000; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        check("mid_busy_before", busy4, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_bin",  bin4,  0);
        check("mid_rst_busy", busy4, 0);
        check("mid_rst_done", done4, 0);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        repeat (12) begin
            @(negedge clk);
            if (done4) dn++;
        end
        check("mid_rst_no_done", dn, 0);

        // Random isolated decodes against the model.
        repeat (12) begin
            rv = 4'($urandom);
            run_one(rv, ref4(rv), 1'b0, "rand4", st);
        end

        // Back-to-back with start held, Gray of 0..15.
        k_acc = 0; k_done = 0; last_done = -1; cyc = 0; prev_busy = 1'b0;
        @(negedge clk);
        g4 = 4'b0000; start4 = 1'b1;
        while (k_done < 16 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (busy4 && !prev_busy) begin
                k_acc++;
                g4 = 4'(k_acc ^ (k_acc >> 1));
                if (k_acc >= 16) start4 = 1'b0;
            end
            prev_busy = busy4;
            if (done4) begin
                check("b2b_bin", bin4, k_done);
                if (last_done >= 0) check("b2b_gap", cyc - last_done, 6);
                last_done = cyc;
                k_done++;
            end
        end
        start4 = 1'b0;
        check("b2b_count", k_done, 16);

        // W=8: all 256 Gray words (permuted by a random mask), back-to-back.
        mask = 8'($urandom);
        k_acc = 0; k_done = 0; last_done = -1; cyc = 0; prev_busy = 1'b0;
        @(negedge clk);
        g8 = mask; start8 = 1'b1;
        while (k_done < 256 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (busy8 && !prev_busy) begin
                q8.push_back(g8);
                k_acc++;
                g8 = 8'(k_acc) ^ mask;
                if (k_acc >= 256) start8 = 1'b0;
            end
            prev_busy = busy8;
            if (done8) begin
                sent = (q8.size() > 0) ? q8.pop_front() : 8'h00;
                check("w8_bin", bin8, ref_bin(sent, 8));
                if (last_done >= 0) check("w8_gap", cyc - last_done, 10);
                last_done = cyc;
                k_done++;
            end
        end
        start8 = 1'b0;
        check("w8_count", k_done, 256);

`ifdef GRAY_DEC_STEP_CHECK_EN
        do_reset();
        rv = 4'($urandom);
        run_one(rv, ref4(rv), 1'b0, "step_first", st);
        check("step_first_err", st, 0);

        do_reset();
        run_one(4'b0110, 4'b0100, 1'b0, "step_a", st);
        check("step_a_err", st, 0);
        run_one(4'b0111, 4'b0101, 1'b0, "step_b", st);
        check("step_b_err", st, 0);
        run_one(4'b0100, 4'b0111, 1'b0, "step_c", st);
        check("step_c_err", st, 1);
        repeat (3) @(negedge clk);
        check("step_hold", step4, 1);
        run_one(4'b0100, 4'b0111, 1'b0, "step_same", st);
        check("step_same_err", st, 0);
        rv = 4'b0100;
        repeat (10) begin
            logic [3:0] nv;
            nv = 4'($urandom);
            run_one(nv, ref4(nv), 1'b0, "step_rand", st);
            check("step_rand_err", st, ($countones(nv ^ rv) > 1) ? 1 : 0);
            rv = nv;
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gray_to_bin_decoder.md
Name: gray_to_bin_decoder

Overview:
- Sequential Gray-to-binary decoder; the receive-side counterpart of the team's binary-to-Gray converter.
- Resolves one binary bit per clock, MSB first: b[i] = b[i+1] ^ g[i].
- Uses a start/busy/done handshake.
- Sits after Gray-coded position or counter sources, e.g. encoder or CDC pointer capture, and delivers registered binary to downstream logic.

Parameters:
- W, 4, data width in bits; legal range 2..32.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- g_in  input  W  Gray code word; sampled only on the accept cycle
- start  input  1  request decode; accepted only in IDLE
- bin_out  output  W  registered binary result; holds its value between completions
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse, coincident with bin_out update
- step_err  output  1  present only with GRAY_DEC_STEP_CHECK_EN; see Optional Feature

Behaviour:
- Reset, on rst=1 at any time, including mid-decode:
  - State returns to IDLE; partial result is discarded.
  - bin_out=0, done=0, busy=0, internal shift/accumulator registers=0, bit counter=0, step_err=0.
- States: IDLE, DECODE, DONE.
- IDLE:
  - busy=0.
  - If start=1, capture g_in into the Gray shadow register, set counter=W-1, set the running bit to 0, and go to DECODE.
- DECODE, one bit per cycle at index idx=counter:
  - r[idx] = prev ^ gshadow[idx], where prev is the previously resolved bit, 0 for the MSB.
  - At idx=0, go to DONE; otherwise decrement the counter.
  - Duration is exactly W cycles.
- DONE, one cycle:
  - bin_out <= r; done=1; then return to IDLE.
- Latency:
  - start sampled at edge N; done=1 and the new bin_out are visible after edge N+W+1.
  - busy is high for W+1 cycles.
  - Minimum start-to-start spacing is W+2 cycles.
- start while busy=1 is ignored, not queued. g_in changes after acceptance do not affect the result.
- bin_out only changes at DONE. It never shows partial values.
- start held continuously produces back-to-back decodes every W+2 cycles. Each decode samples g_in on its own accept cycle.
- No arithmetic overflow exists; all operations are bitwise, W wide.

Optional Feature:
- Macro: GRAY_DEC_STEP_CHECK_EN.
- With the macro defined:
  - Adds output step_err, the previous-accepted Gray register, and a first-sample flag.
  - On each accept after the first since reset, compute the Hamming distance between g_in and the previous accepted Gray word.
  - If the distance is greater than 1, step_err=1, registered at the same DONE cycle as done, and held until the next DONE.
  - Distance 0 (same value) or 1 gives step_err=0.
  - The first accept after reset never flags.
- Without the macro:
  - No step_err port, and no extra registers.
  - Core behaviour and timing are identical.

Decomposition:
- Shared package gray_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_DECODE=2'd1, ST_DONE=2'd2;
  - default width constant GRAY_W_DEFAULT=4.
- One natural sub-module: gray_hamming_gt1. Combinational, W-bit inputs a and b; output is 1 when popcount(a^b) > 1. Instantiated only under GRAY_DEC_STEP_CHECK_EN.
- The FSM, counter and accumulator stay in the top module.

Test Plan:
- Reset: assert rst mid-DECODE, with g_in=4'b1000 accepted 2 cycles earlier -> bin_out=0, busy=0, done=0 immediately. No done pulse follows.
- Basic decode: g_in=4'b0110, start for 1 cycle -> busy high 5 cycles; done pulses once at accept+5 edges; bin_out=4'b0100.
- Corner values:
  - g_in=4'b0000 -> bin_out=4'b0000.
  - g_in=4'b1000 -> bin_out=4'b1111.
  - g_in=4'b1111 -> bin_out=4'b1010.
- Ignored start: accept g_in=4'b0011, then pulse start with g_in=4'b1100 while busy -> single done, bin_out=4'b0010. The second request is never decoded.
- Back-to-back and exhaustive: start held high, g_in stepping through the Gray code of 0..15 -> done every 6 cycles, bin_out=0,1,...,15 in order. Also run with W=8 over 256 values against a model.
- Step check, macro defined:
  - Accept sequence 0110, 0111, 0100 -> step_err=0, 0, 1 at the respective done cycles.
  - First accept after reset with any value -> step_err=0.
